// File: rtl/key_pkg.sv
// Shared constants and FSM state type for the push-button capture path.
package key_pkg;

  localparam int                   KEY_WIDTH               = 4;
  localparam logic [KEY_WIDTH-1:0] KEY_NONE                = 4'b0000;
  localparam int                   DEBOUNCE_CYCLES_DEFAULT = 50000;

  typedef enum logic {
    IDLE    = 1'b0,
    PRESSED = 1'b1
  } key_state_t;

endpackage

// File: rtl/key_synchroniser.sv
// Two-flop synchroniser for asynchronous active-low inputs.
// Flops reset to 1, so the reset state reads as "released".
module key_synchroniser #(
  parameter int WIDTH = 4
) (
  input  logic             i_clock,
  input  logic             i_reset,
  input  logic [WIDTH-1:0] i_async,
  output logic [WIDTH-1:0] o_sync
);

  logic [WIDTH-1:0] r_meta;
  logic [WIDTH-1:0] r_sync;

  // Metastability chain: first stage may go metastable, second stage resolves it.
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      r_meta <= '1;
      r_sync <= '1;
    end else begin
      r_meta <= i_async;
      r_sync <= r_meta;
    end
  end

  assign o_sync = r_sync;

endmodule

// File: rtl/key_capture.sv
// DE1 push-button front end: synchronise, debounce the whole key vector,
// and turn presses into a held one-hot key code plus a single-cycle strobe.
module key_capture
  import key_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [KEY_WIDTH-1:0] key_n,
  output logic [KEY_WIDTH-1:0] key_onehot,
  output logic                 key_valid,
  output logic                 key_held
);

  localparam int                CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [KEY_WIDTH-1:0] w_sync_n;
  logic [KEY_WIDTH-1:0] w_sync;
  logic [KEY_WIDTH-1:0] r_candidate;
  logic [KEY_WIDTH-1:0] r_stable;
  logic                 r_held;
  logic [CNT_W-1:0]     r_count;
  key_state_t           r_state;
  logic [KEY_WIDTH-1:0] r_onehot;
  logic                 r_valid;

  // Isolate the lowest set bit: the lowest key index wins on simultaneous presses.
  function automatic logic [KEY_WIDTH-1:0] pick_lowest(input logic [KEY_WIDTH-1:0] keys);
    pick_lowest = keys & (~keys + 4'd1);
  endfunction

  key_synchroniser #(
    .WIDTH (KEY_WIDTH)
  ) u_sync (
    .i_clock (clock),
    .i_reset (reset),
    .i_async (key_n),
    .o_sync  (w_sync_n)
  );

  assign w_sync = ~w_sync_n;

  // Shared debouncer: the candidate load is the first stable sample, so the
  // level is accepted on the edge that sees the DEBOUNCE_CYCLES-th equal sample.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_candidate <= KEY_NONE;
      r_stable    <= KEY_NONE;
      r_held      <= 1'b0;
      r_count     <= '0;
    end else if (w_sync != r_candidate) begin
      r_candidate <= w_sync;
      r_count     <= '0;
      if (DEBOUNCE_CYCLES == 1) begin
        r_stable <= w_sync;
        r_held   <= |w_sync;
      end
    end else if (r_count < CNT_LAST) begin
      r_count <= r_count + CNT_W'(1);
      if (r_count == CNT_LAST - CNT_W'(1)) begin
        r_stable <= r_candidate;
        r_held   <= |r_candidate;
      end
    end else begin
      r_stable <= r_candidate;
      r_held   <= |r_candidate;
    end
  end

  // Press FSM: accept one key per press episode; ignore roll-over keys until all released.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state  <= IDLE;
      r_onehot <= KEY_NONE;
      r_valid  <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (r_stable != KEY_NONE) begin
            r_onehot <= pick_lowest(r_stable);
            r_valid  <= 1'b1;
            r_state  <= PRESSED;
          end else begin
            r_valid  <= 1'b0;
          end
        end
        PRESSED: begin
          r_valid <= 1'b0;
          if (r_stable == KEY_NONE) begin
            r_state <= IDLE;
          end else begin
            r_state <= PRESSED;
          end
        end
        default: begin
          r_state <= IDLE;
          r_valid <= 1'b0;
        end
      endcase
    end
  end

  assign key_onehot = r_onehot;
  assign key_valid  = r_valid;
  assign key_held   = r_held;

endmodule

// File: tb/tb_key_capture.sv
// Scoreboard bench for key_capture with a 4-cycle debounce interval.
module tb_key_capture;

  localparam int DEB = 4;

  typedef struct {
    logic [3:0] onehot;
    int         edge_n;
  } exp_t;

  logic       clock;
  logic       reset;
  logic [3:0] key_n;
  logic [3:0] key_onehot;
  logic       key_valid;
  logic       key_held;

  int   n_vec;
  int   n_err;
  int   cyc;
  logic prev_valid;
  exp_t sb_q[$];

  key_capture #(
    .DEBOUNCE_CYCLES (DEB)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .key_n      (key_n),
    .key_onehot (key_onehot),
    .key_valid  (key_valid),
    .key_held   (key_held)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Per-cycle monitor: every strobe must match the oldest expected press.
  task automatic monitor();
    exp_t e;
    check("onehot_legal", 32'($countones(key_onehot) <= 1), 32'd1);
    if (key_valid) begin
      if (prev_valid) check("valid_back_to_back", 32'd1, 32'd0);
      if (sb_q.size() == 0) begin
        check("unexpected_valid", 32'd1, 32'd0);
      end else begin
        e = sb_q.pop_front();
        check("valid_onehot", 32'(key_onehot), 32'(e.onehot));
        check("valid_edge", 32'(cyc), 32'(e.edge_n));
      end
    end
    prev_valid = key_valid;
  endtask

  task automatic step();
    @(posedge clock);
    cyc++;
    #1;
    monitor();
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  // Drive a press that must be accepted: strobe expected DEB+3 edges later.
  task automatic press(input logic [3:0] kn, input logic [3:0] exp_onehot);
    exp_t e;
    key_n    = kn;
    e.onehot = exp_onehot;
    e.edge_n = cyc + DEB + 3;
    sb_q.push_back(e);
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_onehot"}, 32'(key_onehot), 32'd0);
    check({tag, "_valid"},  32'(key_valid),  32'd0);
    check({tag, "_held"},   32'(key_held),   32'd0);
  endtask

  initial begin
    n_vec      = 0;
    n_err      = 0;
    cyc        = 0;
    prev_valid = 1'b0;
    reset      = 1'b1;
    key_n      = 4'b1111;

    // Reset with all keys released.
    #1;
    check_outputs_zero("reset_async");
    for (int i = 0; i < 3; i++) begin
      step();
      check_outputs_zero("reset_held");
    end
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      check_outputs_zero("reset_after");
    end

    // Single press of KEY2; key_held rises one edge before the strobe.
    press(4'b1011, 4'b0100);
    for (int k = 1; k <= 12; k++) begin
      step();
      check("press_held", 32'(key_held), 32'(k >= DEB + 2));
    end
    check("press_onehot", 32'(key_onehot), 32'h4);
    key_n = 4'b1111;
    for (int k = 1; k <= 12; k++) begin
      step();
      check("release_held", 32'(key_held), 32'(k < DEB + 2));
    end
    check("release_onehot_kept", 32'(key_onehot), 32'h4);

    // Bounce on KEY0: 2-cycle toggles never reach the debounce interval.
    for (int i = 0; i < 6; i++) begin
      key_n = (i % 2 == 0) ? 4'b1110 : 4'b1111;
      steps(2);
    end
    press(4'b1110, 4'b0001);
    steps(12);
    check("bounce_onehot", 32'(key_onehot), 32'h1);
    key_n = 4'b1111;
    steps(12);

    // Simultaneous KEY1 and KEY3: lowest index wins.
    press(4'b0101, 4'b0010);
    steps(12);
    check("simul_onehot", 32'(key_onehot), 32'h2);
    key_n = 4'b1111;
    steps(12);

    // Roll-over: adding KEY3 while KEY0 is held yields no new strobe.
    press(4'b1110, 4'b0001);
    steps(12);
    key_n = 4'b0110;
    steps(12);
    check("rollover_onehot", 32'(key_onehot), 32'h1);
    check("rollover_held", 32'(key_held), 32'd1);
    key_n = 4'b1111;
    steps(12);
    press(4'b0111, 4'b1000);
    steps(12);
    check("key3_onehot", 32'(key_onehot), 32'h8);
    key_n = 4'b1111;
    steps(12);

    // Reset mid-debounce with KEY1 held throughout.
    key_n = 4'b1101;
    steps(3);
    reset = 1'b1;
    #1;
    check_outputs_zero("midreset_async");
    for (int i = 0; i < 2; i++) begin
      step();
      check_outputs_zero("midreset_held");
    end
    reset = 1'b0;
    press(4'b1101, 4'b0010);
    steps(12);
    check("midreset_onehot", 32'(key_onehot), 32'h2);
    key_n = 4'b1111;
    steps(12);

    check("scoreboard_drained", 32'(sb_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/key_capture.md
# key_capture

Input-side counterpart of the key-to-7-segment encoder.
- Takes the four raw active-low DE1 push-buttons.
- Synchronises and debounces them, and resolves presses into a one-hot key code with a single-cycle press strobe.
- `key_onehot` feeds the display encoder directly. `key_valid` is available to any logic that counts or reacts to presses.

## Interface
- `DEBOUNCE_CYCLES`, default 50000: stable-input cycles needed before a level change is accepted (1 ms at 50 MHz). Legal range is ≥1; benches use 4.
- `clock` in, 1: system clock; all state updates on its rising edge.
- `reset` in, 1: asynchronous, active-high; clears all state immediately.
- `key_n` in, 4: raw DE1 KEY[3:0], active-low, asynchronous to `clock`.
- `key_onehot` out, 4: last accepted key, one-hot (bit i = KEY[i]); 4'b0000 when none accepted since reset.
- `key_valid` out, 1: one-cycle pulse in the cycle `key_onehot` takes a new accepted press.
- `key_held` out, 1: high while the debounced vector has any key down.

## Operation
- Synchroniser: two flops per bit on `key_n`, then invert to active-high `sync[3:0]`. Flop reset value is 1 (released), so `sync` resets to 0.
- Debouncer: one shared counter over the whole 4-bit vector, plus a `candidate` register and a `stable` register.
  - `sync != candidate`: `candidate <= sync`, counter cleared to 0.
  - Otherwise, while counter < `DEBOUNCE_CYCLES-1`: counter increments.
  - Otherwise (counter == `DEBOUNCE_CYCLES-1`): `stable <= candidate`; counter saturates.
  - Counter width is $clog2(DEBOUNCE_CYCLES+1). It never wraps.
- FSM, two states, reset state `IDLE`:
  - `IDLE`: when `stable != 0`, latch the lowest-indexed set bit of `stable` as one-hot into `key_onehot`, pulse `key_valid`, and go to `PRESSED`.
  - `PRESSED`: extra keys pressed are ignored, with no update and no pulse. When `stable == 0`, go to `IDLE`.
- `key_onehot` holds its value through release and through `IDLE`. It changes only on an accepted press or on reset.
- `key_held` = (`stable != 0`), registered alongside `stable`.
- Simultaneous presses (several bits reach `stable` in the same cycle): the lowest index wins. Exactly one bit of `key_onehot` is set after any press.
- Bounce: any toggle shorter than `DEBOUNCE_CYCLES` cycles restarts the counter. No pulses are produced during bounce.
- Reset mid-operation: all outputs go to 0 asynchronously. Debounce progress is discarded. After reset deassert, a key still held needs a full debounce interval, then produces one `key_valid`.

## Timing
- Reset values: `key_onehot` = 4'b0000, `key_valid` = 0, `key_held` = 0, state = `IDLE`, counter = 0, `candidate` = `stable` = 0.
- Press latency, counted from the first rising edge that samples the new `key_n` level with it held stable:
  - `key_valid` and `key_onehot` update on edge `DEBOUNCE_CYCLES+3`.
  - `key_held` rises one edge earlier, on edge `DEBOUNCE_CYCLES+2`.
- Release latency: `key_held` falls on edge `DEBOUNCE_CYCLES+2`. The FSM reaches `IDLE` one edge later.
- Minimum press-to-press spacing: one full release debounce plus one press debounce.
- `key_valid` is never high on two consecutive cycles.

## Structure
- Package `key_pkg` holds:
  - `KEY_WIDTH` = 4
  - `KEY_NONE` = 4'b0000
  - FSM state typedef {`IDLE`, `PRESSED`}
  - the default `DEBOUNCE_CYCLES` constant
- Sub-module `key_synchroniser`: parameterised-width two-flop synchroniser with reset value 1. It is reusable for the switch inputs.
- Debounce counter, priority pick and FSM live in `key_capture`.

## Test plan
All scenarios use `DEBOUNCE_CYCLES` = 4.
- Reset: assert `reset` with `key_n` = 4'b1111. Required: `key_onehot` = 0000, `key_valid` = 0, `key_held` = 0 throughout reset and after release.
- Single press: drive `key_n` = 4'b1011 for 12 cycles. Required: `key_valid` high only on edge 7, `key_onehot` = 0100, `key_held` high from edge 6. Then drive 4'b1111. Required: `key_held` low at edge 6 after release, `key_onehot` still 0100.
- Bounce: toggle `key_n[0]` every 2 cycles for 12 cycles, then hold it low. Required: no pulse during the toggling, then exactly one `key_valid`, with `key_onehot` = 0001.
- Simultaneous press: `key_n` goes from 4'b1111 to 4'b0101 in one cycle. Required: one `key_valid`, `key_onehot` = 0010.
- Roll-over: hold KEY0 until it is accepted, then add KEY3 (`key_n` = 4'b0110). Required: no new pulse, `key_onehot` stays 0001. Release all, then press KEY3 alone. Required: one pulse, `key_onehot` = 1000.
- Reset mid-debounce: press KEY1 and assert `reset` at cycle 3 for 2 cycles, keeping KEY1 held. Required: outputs 0 during reset, then one `key_valid` with `key_onehot` = 0010 exactly 7 edges after reset deasserts.
